// File: rtl/uart_fifo_mmio.sv
// rtl/uart_fifo_mmio.sv - FIFO-buffered MMIO UART: baud divisor, 16x RX oversampling, error flags, IRQ
// Optional even parity on TX/RX when UART_PARITY_EN is defined.
module uart_fifo_mmio #(
    parameter logic [31:0] BASE_ADDR   = 32'h40000018,
    parameter int          TX_DEPTH    = 4,
    parameter int          RX_DEPTH    = 4,
    parameter logic [15:0] DIV_DEFAULT = 16'd324
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);
`ifdef UART_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam logic [TAW:0] TX_FULL_CNT = (TAW+1)'(TX_DEPTH);
    localparam logic [RAW:0] RX_FULL_CNT = (RAW+1)'(RX_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_e;

    logic sel_txd, sel_rxd, sel_con, sel_div;
    logic wr_txd, wr_con, wr_div;
    assign sel_txd = (addr == BASE_ADDR);
    assign sel_rxd = (addr == BASE_ADDR + 32'd4);
    assign sel_con = (addr == BASE_ADDR + 32'd8);
    assign sel_div = (addr == BASE_ADDR + 32'd12);
    assign wr_txd  = wr & sel_txd;
    assign wr_con  = wr & sel_con;
    assign wr_div  = wr & sel_div;

    logic unused_wdata_hi;
    assign unused_wdata_hi = ^wdata[31:16];

    logic [7:0]  txd_q;
    logic [15:0] div_q;
    logic        tx_ie_q, rx_ie_q, ovr_q, fe_q, pe_q;
    logic        ovr_d, fe_d, pe_d;

    logic [7:0]     tx_mem [TX_DEPTH];
    logic [TAW-1:0] tx_wp_q, tx_rp_q;
    logic [TAW:0]   tx_cnt_q;
    logic           tx_empty, tx_full, tx_push, tx_pop, tx_busy;
    logic [7:0]     tx_head;
    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == TX_FULL_CNT);
    assign tx_push  = wr_txd & ~tx_full;
    assign tx_head  = tx_mem[tx_rp_q];

    logic [7:0]     rx_mem [RX_DEPTH];
    logic [RAW-1:0] rx_wp_q, rx_rp_q;
    logic [RAW:0]   rx_cnt_q;
    logic           rx_empty, rx_full, rx_push, rx_pop;
    logic [7:0]     rx_head;
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == RX_FULL_CNT);
    assign rx_pop   = rd & sel_rxd & ~rx_empty;
    assign rx_head  = rx_mem[rx_rp_q];

    state_e      tx_state_q, tx_state_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [3:0]  tx_sub_q, tx_sub_d;
    logic [15:0] tx_pre_q, tx_pre_d;
    logic        tx_line_q, tx_line_d, tx_par_q, tx_par_d;
    logic        tx_tick, tx_bit_end;
    assign tx_tick    = (tx_pre_q == div_q);
    assign tx_bit_end = tx_tick && (tx_sub_q == 4'd15);
    assign tx_busy    = (tx_state_q != S_IDLE) | ~tx_empty;

    // Each bit is 16 ticks; the prescaler restarts on every load so frames are exactly sized.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_sh_d    = tx_sh_q;
        tx_bit_d   = tx_bit_q;
        tx_par_d   = tx_par_q;
        tx_line_d  = tx_line_q;
        tx_pop     = 1'b0;
        tx_pre_d   = tx_tick ? 16'd0 : tx_pre_q + 16'd1;
        tx_sub_d   = tx_tick ? tx_sub_q + 4'd1 : tx_sub_q;
        case (tx_state_q)
            S_IDLE: begin
                tx_line_d = 1'b1;
                tx_pop    = ~tx_empty;
            end
            S_START: if (tx_bit_end) begin
                tx_state_d = S_DATA;
                tx_line_d  = tx_sh_q[0];
            end
            S_DATA: if (tx_bit_end) begin
                if (tx_bit_q == 3'd7) begin
                    tx_state_d = PAR_EN ? S_PAR : S_STOP;
                    tx_line_d  = PAR_EN ? tx_par_q : 1'b1;
                end else begin
                    tx_bit_d  = tx_bit_q + 3'd1;
                    tx_sh_d   = {1'b0, tx_sh_q[7:1]};
                    tx_line_d = tx_sh_q[1];
                end
            end
            S_PAR: if (tx_bit_end) begin
                tx_state_d = S_STOP;
                tx_line_d  = 1'b1;
            end
            S_STOP: if (tx_bit_end) begin
                tx_state_d = S_IDLE;
                tx_line_d  = 1'b1;
                tx_pop     = ~tx_empty;
            end
            default: tx_state_d = S_IDLE;
        endcase
        if (tx_pop) begin
            tx_state_d = S_START;
            tx_sh_d    = tx_head;
            tx_par_d   = ^tx_head;
            tx_bit_d   = 3'd0;
            tx_line_d  = 1'b0;
        end
        if (tx_state_q == S_IDLE || tx_pop) begin
            tx_pre_d = 16'd0;
            tx_sub_d = 4'd0;
        end
        if (wr_div) tx_pre_d = 16'd0;
    end

    logic        rx_s1_q, rx_s2_q, rx_s3_q, rx_fall;
    state_e      rx_state_q, rx_state_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [3:0]  rx_sub_q, rx_sub_d;
    logic [15:0] rx_pre_q, rx_pre_d;
    logic        rx_tick, rx_mid, rx_end, ovr_set, fe_set, pe_set;
    assign rx_fall = rx_s3_q & ~rx_s2_q;
    assign rx_tick = (rx_pre_q == div_q);
    assign rx_mid  = rx_tick && (rx_sub_q == 4'd7);
    assign rx_end  = rx_tick && (rx_sub_q == 4'd15);

    // Receiver returns to IDLE at the stop-bit midpoint so a back-to-back start edge is not missed.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_sh_d    = rx_sh_q;
        rx_bit_d   = rx_bit_q;
        rx_push    = 1'b0;
        ovr_set    = 1'b0;
        fe_set     = 1'b0;
        pe_set     = 1'b0;
        rx_pre_d   = rx_tick ? 16'd0 : rx_pre_q + 16'd1;
        rx_sub_d   = rx_tick ? rx_sub_q + 4'd1 : rx_sub_q;
        case (rx_state_q)
            S_IDLE: if (rx_fall) rx_state_d = S_START;
            S_START: begin
                if (rx_mid && rx_s2_q) begin
                    rx_state_d = S_IDLE;
                end else if (rx_end) begin
                    rx_state_d = S_DATA;
                    rx_bit_d   = 3'd0;
                end
            end
            S_DATA: begin
                if (rx_mid) rx_sh_d = {rx_s2_q, rx_sh_q[7:1]};
                if (rx_end) begin
                    if (rx_bit_q == 3'd7) rx_state_d = PAR_EN ? S_PAR : S_STOP;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end
            end
            S_PAR: begin
                if (rx_mid) pe_set = rx_s2_q ^ (^rx_sh_q);
                if (rx_end) rx_state_d = S_STOP;
            end
            S_STOP: if (rx_mid) begin
                rx_state_d = S_IDLE;
                if (!rx_s2_q)    fe_set  = 1'b1;
                else if (rx_full) ovr_set = 1'b1;
                else             rx_push = 1'b1;
            end
            default: rx_state_d = S_IDLE;
        endcase
        if (rx_state_q == S_IDLE) begin
            rx_pre_d = 16'd0;
            rx_sub_d = 4'd0;
        end
        if (wr_div) rx_pre_d = 16'd0;
    end

    // Hardware set of an error flag takes priority over a same-cycle W1C.
    assign ovr_d = (ovr_q & ~(wr_con & wdata[5])) | ovr_set;
    assign fe_d  = (fe_q  & ~(wr_con & wdata[6])) | fe_set;
    assign pe_d  = PAR_EN & ((pe_q & ~(wr_con & wdata[7])) | pe_set);

    always_comb begin
        rdata = 32'd0;
        if (rd) begin
            if (sel_txd)      rdata = {24'd0, txd_q};
            else if (sel_rxd) rdata = {24'd0, rx_empty ? 8'd0 : rx_head};
            else if (sel_con) rdata = {24'd0, pe_q, fe_q, ovr_q, tx_full, ~rx_empty, tx_busy, rx_ie_q, tx_ie_q};
            else if (sel_div) rdata = {16'd0, div_q};
        end
    end

    assign uart_tx = tx_line_q;
    assign irq     = (rx_ie_q & ~rx_empty) | (tx_ie_q & ~tx_busy);

    always_ff @(posedge sys_clk) begin
        if (tx_push) tx_mem[tx_wp_q] <= wdata[7:0];
        if (rx_push) rx_mem[rx_wp_q] <= rx_sh_q;
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            txd_q      <= 8'd0;
            div_q      <= DIV_DEFAULT;
            tx_ie_q    <= 1'b0;
            rx_ie_q    <= 1'b0;
            ovr_q      <= 1'b0;
            fe_q       <= 1'b0;
            pe_q       <= 1'b0;
            tx_wp_q    <= '0;
            tx_rp_q    <= '0;
            tx_cnt_q   <= '0;
            rx_wp_q    <= '0;
            rx_rp_q    <= '0;
            rx_cnt_q   <= '0;
            tx_state_q <= S_IDLE;
            tx_sh_q    <= 8'd0;
            tx_bit_q   <= 3'd0;
            tx_sub_q   <= 4'd0;
            tx_pre_q   <= 16'd0;
            tx_line_q  <= 1'b1;
            tx_par_q   <= 1'b0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_s3_q    <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_sh_q    <= 8'd0;
            rx_bit_q   <= 3'd0;
            rx_sub_q   <= 4'd0;
            rx_pre_q   <= 16'd0;
        end else begin
            if (wr_txd) txd_q <= wdata[7:0];
            if (wr_div) div_q <= wdata[15:0];
            if (wr_con) begin
                tx_ie_q <= wdata[0];
                rx_ie_q <= wdata[1];
            end
            ovr_q <= ovr_d;
            fe_q  <= fe_d;
            pe_q  <= pe_d;
            if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
            if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
            tx_cnt_q <= tx_cnt_q + {{TAW{1'b0}}, tx_push} - {{TAW{1'b0}}, tx_pop};
            if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
            if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
            rx_cnt_q <= rx_cnt_q + {{RAW{1'b0}}, rx_push} - {{RAW{1'b0}}, rx_pop};
            tx_state_q <= tx_state_d;
            tx_sh_q    <= tx_sh_d;
            tx_bit_q   <= tx_bit_d;
            tx_sub_q   <= tx_sub_d;
            tx_pre_q   <= tx_pre_d;
            tx_line_q  <= tx_line_d;
            tx_par_q   <= tx_par_d;
            rx_s1_q    <= uart_rx;
            rx_s2_q    <= rx_s1_q;
            rx_s3_q    <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_sh_q    <= rx_sh_d;
            rx_bit_q   <= rx_bit_d;
            rx_sub_q   <= rx_sub_d;
            rx_pre_q   <= rx_pre_d;
        end
    end
endmodule

// File: tb/tb_uart_fifo_mmio.sv
// tb/tb_uart_fifo_mmio.sv - scoreboard bench for uart_fifo_mmio (bus reads and decoded TX frames)
module tb_uart_fifo_mmio;
    localparam logic [31:0] A_TXD = 32'h40000018;
    localparam logic [31:0] A_RXD = 32'h4000001C;
    localparam logic [31:0] A_CON = 32'h40000020;
    localparam logic [31:0] A_DIV = 32'h40000024;
    localparam logic [31:0] ALL   = 32'hFFFFFFFF;

    logic        sys_clk = 1'b0;
    logic        reset   = 1'b0;
    logic        rd      = 1'b0;
    logic        wr      = 1'b0;
    logic [31:0] addr    = 32'd0;
    logic [31:0] wdata   = 32'd0;
    logic [31:0] rdata;
    logic        uart_rx = 1'b1;
    logic        uart_tx;
    logic        irq;

    uart_fifo_mmio dut (
        .sys_clk(sys_clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr),
        .wdata(wdata), .rdata(rdata), .uart_rx(uart_rx), .uart_tx(uart_tx), .irq(irq)
    );

    always #5 sys_clk = ~sys_clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          tx_frames = 0;
    int          f0;
    logic [31:0] rd_exp_q [$];
    logic [31:0] rd_mask_q [$];
    string       rd_name_q [$];
    logic [7:0]  tx_exp_q [$];
    logic [31:0] mon_e, mon_m;
    string       mon_nm;
    logic        tx_abort = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        @(posedge sys_clk); #2;
        wr = 1'b1; rd = 1'b0; addr = a; wdata = d;
    endtask

    task automatic bus_idle();
        @(posedge sys_clk); #2;
        wr = 1'b0; rd = 1'b0;
    endtask

    task automatic wr1(input logic [31:0] a, input logic [31:0] d);
        bus_wr(a, d);
        bus_idle();
    endtask

    task automatic rd1(input logic [31:0] a, input logic [31:0] e, input logic [31:0] m, input string nm);
        @(posedge sys_clk); #2;
        rd_exp_q.push_back(e);
        rd_mask_q.push_back(m);
        rd_name_q.push_back(nm);
        rd = 1'b1; wr = 1'b0; addr = a;
        @(posedge sys_clk); #2;
        rd = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(posedge sys_clk); #2;
        uart_rx = 1'b0;
        repeat (16) @(posedge sys_clk);
        for (int i = 0; i < 8; i++) begin
            #2 uart_rx = b[i];
            repeat (16) @(posedge sys_clk);
        end
        #2 uart_rx = stop_bit;
        repeat (16) @(posedge sys_clk);
        #2 uart_rx = 1'b1;
    endtask

    always @(negedge sys_clk) begin
        if (reset === 1'b1 && rd === 1'b1) begin
            if (rd_exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL rd_unexpected: got 0x%08h expected no read", rdata);
            end else begin
                mon_e  = rd_exp_q.pop_front();
                mon_m  = rd_mask_q.pop_front();
                mon_nm = rd_name_q.pop_front();
                chk(mon_nm, rdata & mon_m, mon_e);
            end
        end
    end

    always @(negedge reset) tx_abort = 1'b1;

    initial begin : tx_mon
        logic [9:0] fr;
        logic [7:0] e;
        forever begin
            @(negedge sys_clk);
            if (reset === 1'b1 && uart_tx === 1'b0) begin
                tx_abort = 1'b0;
                repeat (8) @(negedge sys_clk);
                fr[0] = uart_tx;
                for (int i = 1; i < 10; i++) begin
                    repeat (16) @(negedge sys_clk);
                    fr[i] = uart_tx;
                end
                if (!tx_abort) begin
                    tx_frames++;
                    if (tx_exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL tx_unexpected_frame: got 0x%03h expected none", fr);
                    end else begin
                        e = tx_exp_q.pop_front();
                        chk("tx_frame", {22'd0, fr}, {22'd0, 1'b1, e, 1'b0});
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge sys_clk);
        #2 reset = 1'b1;
        @(posedge sys_clk); #2;
        chk("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rd1(A_TXD, 32'd0, ALL, "rst_txd");
        rd1(A_RXD, 32'd0, ALL, "rst_rxd");
        rd1(A_CON, 32'd0, ALL, "rst_con");
        rd1(A_DIV, 32'd324, ALL, "rst_div");
        wr1(A_DIV, 32'd0);
        rd1(A_DIV, 32'd0, ALL, "div_write");

        // TX pattern 0x55 at DIV=0
        tx_exp_q.push_back(8'h55);
        bus_wr(A_TXD, 32'h55);
        bus_idle();
        chk("tx_high_at_N", {31'd0, uart_tx}, 32'd1);
        @(posedge sys_clk); #1;
        chk("tx_low_at_N1", {31'd0, uart_tx}, 32'd0);
        rd1(A_CON, 32'h4, 32'h4, "tx_busy_mid");
        repeat (170) @(posedge sys_clk);
        rd1(A_CON, 32'h0, 32'h4, "tx_busy_done");
        chk("tx_frames_pattern", tx_frames, 32'd1);
        wr1(A_CON, 32'h1);
        chk("irq_tx_ie", {31'd0, irq}, 32'd1);
        wr1(A_CON, 32'h0);
        chk("irq_off", {31'd0, irq}, 32'd0);

        // TX FIFO full: six back-to-back writes, sixth dropped
        f0 = tx_frames;
        for (int i = 1; i <= 6; i++) begin
            if (i <= 5) tx_exp_q.push_back(8'(i));
            bus_wr(A_TXD, 32'(i));
        end
        bus_idle();
        rd1(A_CON, 32'h14, 32'h14, "tx_full");
        rd1(A_TXD, 32'h06, ALL, "txd_shadow");
        repeat (5 * 160 + 40) @(posedge sys_clk);
        chk("tx_frames_full", tx_frames - f0, 32'd5);
        rd1(A_CON, 32'h0, 32'h14, "tx_drained");

        // RX and interrupt
        wr1(A_CON, 32'h2);
        send_byte(8'hA3, 1'b1);
        repeat (4) @(posedge sys_clk);
        #1 chk("irq_rx", {31'd0, irq}, 32'd1);
        rd1(A_CON, 32'h0A, 32'hFF, "rx_con_avail");
        rd1(A_RXD, 32'h000000A3, ALL, "rxd_a3");
        rd1(A_CON, 32'h02, 32'hFF, "rx_con_empty");
        chk("irq_rx_clear", {31'd0, irq}, 32'd0);

        // RX overrun
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        send_byte(8'h55, 1'b1);
        repeat (4) @(posedge sys_clk);
        rd1(A_CON, 32'h2A, 32'hFF, "ovr_con");
        rd1(A_RXD, 32'h11, ALL, "ovr_rxd1");
        rd1(A_RXD, 32'h22, ALL, "ovr_rxd2");
        rd1(A_RXD, 32'h33, ALL, "ovr_rxd3");
        rd1(A_RXD, 32'h44, ALL, "ovr_rxd4");
        rd1(A_RXD, 32'h00, ALL, "ovr_rxd_empty");
        wr1(A_CON, 32'h20);
        rd1(A_CON, 32'h00, 32'hFF, "ovr_cleared");

        // Glitch and frame error
        @(posedge sys_clk); #2 uart_rx = 1'b0;
        repeat (4) @(posedge sys_clk);
        #2 uart_rx = 1'b1;
        repeat (40) @(posedge sys_clk);
        rd1(A_CON, 32'h00, 32'hFF, "glitch_con");
        send_byte(8'h5A, 1'b0);
        repeat (20) @(posedge sys_clk);
        rd1(A_CON, 32'h40, 32'hFF, "frame_err");
        wr1(A_CON, 32'h40);
        rd1(A_CON, 32'h00, 32'hFF, "frame_err_clear");

        // Reset mid-frame with both FIFOs holding data
        send_byte(8'h77, 1'b1);
        repeat (4) @(posedge sys_clk);
        bus_wr(A_TXD, 32'hC3);
        bus_wr(A_TXD, 32'h3C);
        bus_idle();
        repeat (50) @(posedge sys_clk);
        #2 chk("mid_frame_low", {31'd0, uart_tx}, 32'd0);
        reset = 1'b0;
        #1 chk("rst_mid_uart_tx", {31'd0, uart_tx}, 32'd1);
        chk("rst_mid_irq", {31'd0, irq}, 32'd0);
        repeat (2) @(posedge sys_clk);
        #2 reset = 1'b1;
        rd1(A_CON, 32'h0, ALL, "rst_mid_con");
        rd1(A_DIV, 32'd324, ALL, "rst_mid_div");
        rd1(A_TXD, 32'h0, ALL, "rst_mid_txd");
        repeat (150) @(posedge sys_clk);

        chk("tx_exp_drained", rd_exp_q.size() == 0 ? tx_exp_q.size() : 32'hDEAD, 32'd0);
        chk("rd_exp_drained", rd_exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_fifo_mmio.md
# uart_fifo_mmio

Parametrised memory-mapped UART for the single-cycle MIPS SoC peripheral bus. It replaces the single-byte TX/RX holding registers with TX and RX FIFOs and adds a programmable baud divisor, 16x oversampled receive, error flags and an interrupt line. It runs on one clock, and the CPU accesses it through the same `rd`/`wr`/`addr`/`wdata`/`rdata` bus as the other peripherals.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h40000018: address of TXD. RXD is at +4, CON at +8 and DIV at +C.
- `TX_DEPTH`, default 4: TX FIFO entries. Must be a power of 2, minimum 2.
- `RX_DEPTH`, default 4: RX FIFO entries. Must be a power of 2, minimum 2.
- `DIV_DEFAULT`, default 16'd324: reset value of DIV. Tick rate = sys_clk / (DIV+1), and 1 bit = 16 ticks.

Ports:
- `sys_clk`, in, 1 bit: the only clock. All logic is posedge.
- `reset`, in, 1 bit: asynchronous, **active-low** reset.
- `rd`, in, 1 bit: bus read strobe.
- `wr`, in, 1 bit: bus write strobe.
- `addr`, in, 32 bits: bus address.
- `wdata`, in, 32 bits: bus write data.
- `rdata`, out, 32 bits: combinational read data. Outputs 0 when `rd`=0 or the address does not match.
- `uart_rx`, in, 1 bit: serial input. Asynchronous; the block synchronises it with 2 flops.
- `uart_tx`, out, 1 bit: serial output. Idles high.
- `irq`, out, 1 bit: level interrupt.

## Operation
Registers:
- **TXD (write)**: pushes `wdata[7:0]` into the TX FIFO. If the FIFO is full, the write is dropped.
- **TXD (read)**: returns the last byte written.
- **RXD (read)**: returns `{24'b0, head}` and pops the RX FIFO. If the FIFO is empty, returns 0 and does not pop.
- **CON**:
  - [0] `tx_ie`, RW
  - [1] `rx_ie`, RW
  - [2] `tx_busy`, RO: shifter active or TX FIFO non-empty
  - [3] `rx_avail`, RO: RX FIFO non-empty
  - [4] `tx_full`, RO
  - [5] `overrun`, W1C
  - [6] `frame_err`, W1C
  - [7] `parity_err`, W1C
  - All other bits read 0.
- **DIV**: RW over [15:0]. Writing DIV clears the tick counter.

Interrupt: `irq = (rx_ie & rx_avail) | (tx_ie & ~tx_busy)`.

Transmitter FSM (IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE):
- Leaves IDLE when the TX FIFO is non-empty: pops one byte and drives `uart_tx` low.
- Sends data LSB first. Each bit lasts 16 ticks. Stop bit = 1.
- After STOP, returns to IDLE or starts the next byte immediately (back-to-back frames).

Receiver FSM (IDLE -> START -> DATA -> [PARITY] -> STOP):
- A falling edge on the synchronised `uart_rx` enters START.
- At tick 8 of the start bit, the line is resampled. If it is high, the frame is a glitch and the FSM returns to IDLE.
- Every later bit is sampled at its tick 8.
- Stop bit sampled 0: set `frame_err`, discard the byte.
- RX FIFO full when a good byte completes: set `overrun`, drop the byte, keep the FIFO contents.
- Otherwise: push the byte.

FIFOs:
- A push and a pop in the same cycle are both honoured and leave the count unchanged.
- Pointers wrap modulo depth.
- A full/empty flag comes from a count that is log2(depth)+1 bits wide.

## Timing
- `rdata` is combinational from `addr`/`rd` and the current state. A pop takes effect at the posedge that ends the read cycle.
- A TXD write at edge N makes the FIFO non-empty after N. The shifter loads at edge N+1, and `uart_tx` falls at N+1.
- Frame length = 10 × 16 × (DIV+1) sys_clk cycles, or 11 × with parity.
- A received byte is visible in `rx_avail` 1 cycle after the stop-bit sample.
- Simultaneous CON write and hardware set of an error flag: the hardware set wins.
- Reset (`reset`=0 at any time, including mid-frame):
  - `uart_tx`=1, `irq`=0, FSMs return to IDLE, FIFOs empty.
  - CON writable/W1C bits = 0, DIV = `DIV_DEFAULT`, TXD shadow = 0.
  - A partial frame is abandoned.

## Configuration
- `UART_PARITY_EN` defined:
  - An even-parity bit is inserted after the data bits on TX and checked on RX.
  - An RX parity mismatch sets `parity_err`, and the byte is still pushed.
- `UART_PARITY_EN` undefined:
  - No parity bit; frames are 8N1.
  - CON[7] reads 0 and writes to it are ignored.

## Test plan
- **TX pattern**: DIV=0, write 0x55 to TXD. `uart_tx` is low at edge N+1, then 1,0,1,0,1,0,1,0, then 1. Each bit is 16 cycles, 160 cycles total. `tx_busy`=0 afterwards.
- **TX FIFO full**: depth 4, six consecutive TXD writes (0x01..0x06). 0x01 goes to the shifter, 0x02-0x05 are queued, `tx_full`=1, and 0x06 is dropped. Exactly five frames appear on `uart_tx`.
- **RX and interrupt**: `uart_rx` driven with 0xA3 at DIV=0 and `rx_ie`=1. `rx_avail`=1 and `irq`=1. Reading RXD returns 0x000000A3, then `rx_avail`=0 and `irq`=0.
- **RX overrun**: 5 bytes received without any read, depth 4. `overrun`=1 and RXD reads give bytes 1-4. Writing 0x20 to CON clears `overrun`.
- **Glitch and frame error**: a 4-cycle low pulse produces no byte. A frame with stop=0 sets `frame_err`, and `rx_avail` stays 0.
- **Reset mid-frame**: `reset` asserted 50 cycles into a TX frame. `uart_tx`=1 immediately, the FIFOs are empty, and DIV reads 324.
